// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module   : mem_access_unit_if
// Purpose  : Control-unit to data-memory request/completion bundle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if;
  logic        RAM_enable;
  logic [5:0]  RAM_OpCode;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        MFC;
  logic        misaligned;

  modport master (
    output RAM_enable,
    output RAM_OpCode,
    output addr,
    output data_in,
    input  data_out,
    input  MFC,
    input  misaligned
  );

  modport slave (
    input  RAM_enable,
    input  RAM_OpCode,
    input  addr,
    input  data_in,
    output data_out,
    output MFC,
    output misaligned
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Purpose  : SPARC V8 byte/halfword/word load-store unit over a big-endian
//            byte array, with fixed wait latency and MFC handshake.
//            Optional macro MEM_ALIGN_CHECK_EN rejects misaligned accesses.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_unit_if.slave   bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [1:0] c_SZ_B = 2'd0;
  localparam logic [1:0] c_SZ_H = 2'd1;
  localparam logic [1:0] c_SZ_W = 2'd2;

  localparam logic [5:0] c_OP_LD   = 6'b000000;
  localparam logic [5:0] c_OP_LDUB = 6'b000001;
  localparam logic [5:0] c_OP_LDUH = 6'b000010;
  localparam logic [5:0] c_OP_LDSB = 6'b001001;
  localparam logic [5:0] c_OP_LDSH = 6'b001010;
  localparam logic [5:0] c_OP_ST   = 6'b000100;
  localparam logic [5:0] c_OP_STB  = 6'b000101;
  localparam logic [5:0] c_OP_STH  = 6'b000110;

  localparam logic [3:0] c_LAT = 4'(LATENCY);
  localparam int         c_DEPTH = 1 << ADDR_W;

  logic [1:0]        state_q,    state_d;
  logic [3:0]        cnt_q,      cnt_d;
  logic [5:0]        op_q,       op_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [31:0]       wdata_q,    wdata_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              mfc_q,      mfc_d;
  logic              mis_q,      mis_d;

  logic [7:0]        mem_q [c_DEPTH];

  logic              w_is_load;
  logic              w_is_store;
  logic              w_signed;
  logic [1:0]        w_size;
  logic              w_misalign;
  logic              w_complete;
  logic              w_do_access;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_baddr [4];
  logic [7:0]        w_rbyte [4];
  logic [7:0]        w_wbyte [4];
  logic [3:0]        w_we;
  logic [31:0]       w_load_data;

  // Only the low ADDR_W address bits select a byte; the rest alias.
  generate
    if (ADDR_W < 32) begin : g_addr_hi_unused
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = &{1'b0, bus.addr[31:ADDR_W]};
    end
  endgenerate

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_signed   = 1'b0;
    w_size     = c_SZ_B;
    case (op_q)
      c_OP_LD:   begin w_is_load  = 1'b1; w_size = c_SZ_W; end
      c_OP_LDUB: begin w_is_load  = 1'b1; w_size = c_SZ_B; end
      c_OP_LDUH: begin w_is_load  = 1'b1; w_size = c_SZ_H; end
      c_OP_LDSB: begin w_is_load  = 1'b1; w_size = c_SZ_B; w_signed = 1'b1; end
      c_OP_LDSH: begin w_is_load  = 1'b1; w_size = c_SZ_H; w_signed = 1'b1; end
      c_OP_ST:   begin w_is_store = 1'b1; w_size = c_SZ_W; end
      c_OP_STB:  begin w_is_store = 1'b1; w_size = c_SZ_B; end
      c_OP_STH:  begin w_is_store = 1'b1; w_size = c_SZ_H; end
      default:   ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = (w_is_load || w_is_store) &&
                      (((w_size == c_SZ_H) && addr_q[0]) ||
                       ((w_size == c_SZ_W) && (addr_q[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  // Forced alignment keeps lane addresses inside one aligned unit, so OR-ing
  // in the lane index never carries past the top of the array.
  always_comb begin
    w_base = addr_q;
    if (w_size == c_SZ_H) begin
      w_base[0] = 1'b0;
    end else if (w_size == c_SZ_W) begin
      w_base[1:0] = 2'b00;
    end
    for (int k = 0; k < 4; k++) begin
      w_baddr[k] = w_base | ADDR_W'(k);
      w_rbyte[k] = mem_q[w_baddr[k]];
    end
  end

  assign w_complete  = (state_q == c_WAIT) && (cnt_q == 4'd0);
  assign w_do_access = w_complete && !w_misalign;

  always_comb begin
    w_we = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      w_wbyte[k] = 8'h00;
    end
    case (w_size)
      c_SZ_W: begin
        w_we       = 4'b1111;
        w_wbyte[0] = wdata_q[31:24];
        w_wbyte[1] = wdata_q[23:16];
        w_wbyte[2] = wdata_q[15:8];
        w_wbyte[3] = wdata_q[7:0];
      end
      c_SZ_H: begin
        w_we       = 4'b0011;
        w_wbyte[0] = wdata_q[15:8];
        w_wbyte[1] = wdata_q[7:0];
      end
      default: begin
        w_we       = 4'b0001;
        w_wbyte[0] = wdata_q[7:0];
      end
    endcase
    if (!(w_do_access && w_is_store)) begin
      w_we = 4'b0000;
    end
  end

  always_comb begin
    case (w_size)
      c_SZ_W:  w_load_data = {w_rbyte[0], w_rbyte[1], w_rbyte[2], w_rbyte[3]};
      c_SZ_H:  w_load_data = {{16{w_signed & w_rbyte[0][7]}}, w_rbyte[0], w_rbyte[1]};
      default: w_load_data = {{24{w_signed & w_rbyte[0][7]}}, w_rbyte[0]};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    mfc_d      = mfc_q;
    mis_d      = mis_q;
    case (state_q)
      c_IDLE: begin
        if (bus.RAM_enable) begin
          op_d    = bus.RAM_OpCode;
          addr_d  = bus.addr[ADDR_W-1:0];
          wdata_d = bus.data_in;
          cnt_d   = c_LAT;
          state_d = c_WAIT;
        end
      end
      c_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = c_DONE;
          mfc_d   = 1'b1;
          mis_d   = w_misalign;
          if (w_misalign) begin
            data_out_d = 32'h0;
          end else if (w_is_load) begin
            data_out_d = w_load_data;
          end else if (!w_is_store) begin
            data_out_d = 32'h0;
          end
        end
      end
      c_DONE: begin
        if (!bus.RAM_enable) begin
          state_d = c_IDLE;
          mfc_d   = 1'b0;
          mis_d   = 1'b0;
        end
      end
      default: begin
        state_d = c_IDLE;
        mfc_d   = 1'b0;
        mis_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= c_IDLE;
      cnt_q      <= 4'd0;
      op_q       <= 6'd0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      data_out_q <= 32'h0;
      mfc_q      <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      mfc_q      <= mfc_d;
      mis_q      <= mis_d;
    end
  end

  // Array is not reset; an abort by reset leaves state_q out of WAIT, so no write.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_we[k]) begin
        mem_q[w_baddr[k]] <= w_wbyte[k];
      end
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.MFC        = mfc_q;
  assign bus.misaligned = mis_q;

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Clocked data-memory block that sits directly downstream of the control unit: it consumes `RAM_enable`/`RAM_OpCode` together with the MAR address and MDR write data, performs SPARC V8 byte/halfword/word loads and stores on an internal big-endian byte array, and returns the load data plus the `MFC` completion handshake.

## Interface
- `ADDR_W`, 9: byte-address width of the internal array, which holds 2^ADDR_W bytes.
- `LATENCY`, 2: number of wait cycles inserted before the access completes. Legal range is 0–15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `RAM_enable` input 1: request level from the control unit; must be held high until `MFC` is seen.
- `RAM_OpCode` input 6: SPARC op3 code (see Operation).
- `addr` input 32: byte address from MAR. Only `addr[ADDR_W-1:0]` is used.
- `data_in` input 32: store data from MDR. Byte and halfword stores use the low bits.
- `data_out` output 32: load result, already extended, to the MDR mux.
- `MFC` output 1: memory-function-complete.
- `misaligned` output 1: the completed request was misaligned and was not performed.

## Operation
- FSM states are IDLE, WAIT and DONE.
- **IDLE:**
  - When `RAM_enable`=1 at a rising edge, latch op, `addr[ADDR_W-1:0]` and `data_in`.
  - Load the counter with `LATENCY` and go to WAIT.
  - Input changes after acceptance are ignored.
- **WAIT:**
  - If counter≠0, decrement it.
  - If counter=0, perform the access, set `MFC`=1 and go to DONE.
- **DONE:**
  - Hold `MFC`=1 and `data_out` while `RAM_enable`=1.
  - At the first edge with `RAM_enable`=0, clear `MFC` and go to IDLE. `data_out` holds its value.
- **Loads:**
  - 000000 ld: word.
  - 000001 ldub: byte, zero-extended.
  - 000010 lduh: halfword, zero-extended.
  - 001001 ldsb: byte, sign-extended.
  - 001010 ldsh: halfword, sign-extended.
- **Stores:**
  - 000100 st: word.
  - 000101 stb: byte from `data_in[7:0]`.
  - 000110 sth: halfword from `data_in[15:0]`.
  - A store writes only the addressed bytes.
  - `data_out` is unchanged by a store.
- **Byte order** is big-endian: byte at address A maps to bits [31:24] of the word at A.
- **Any other opcode** completes normally with no array access: `MFC`=1, `data_out`=0, `misaligned`=0.
- **Address range:** there is no wrap inside a single access. An aligned access never crosses the top of the array; higher address bits alias.
- **Reset:**
  - Outputs reset to `MFC`=0, `data_out`=0, `misaligned`=0, state IDLE.
  - Array contents are not reset.
  - Reset during WAIT aborts the request with no write.
- `misaligned` updates only when an access completes, and clears when the FSM returns to IDLE.

## Timing
- A request accepted at edge k asserts `MFC` at edge k+1+`LATENCY`, with `data_out` valid at that same edge.
- With `LATENCY`=0, `MFC` is asserted at edge k+1.
- The store write commits on the same edge that `MFC` rises.
- Back-to-back requests need at least one edge with `RAM_enable`=0: DONE→IDLE, then a new accept. The minimum request period is therefore `LATENCY`+3 cycles.
- `RAM_enable` dropping during WAIT does not cancel the request. It completes, `MFC` pulses for one cycle, and the FSM returns to IDLE.

## Configuration
- `MEM_ALIGN_CHECK_EN`
  - **Defined:**
    - A halfword access with addr[0]=1, or a word access with addr[1:0]≠0, performs no read or write.
    - It completes with `MFC`=1, `misaligned`=1 and `data_out`=0.
  - **Undefined:**
    - Low address bits are forced to alignment: addr[0] is cleared for halfwords, addr[1:0] for words.
    - The access proceeds, and `misaligned` is tied to 0.

## Test plan
- **Reset and latency:**
  - Stimulus: `rst_n`=0, then release; `LATENCY`=2.
  - Check: all outputs are 0.
  - Stimulus: st 0xDEADBEEF at 0x010 with `RAM_enable` held high.
  - Check: `MFC` rises exactly 3 edges after accept.
  - Stimulus: ld from 0x010.
  - Check: `data_out`=0xDEADBEEF.
- **Extension and byte order:**
  - Stimulus: ldub at 0x010.
  - Check: 0x000000DE.
  - Stimulus: ldsb at 0x013.
  - Check: 0xFFFFFFEF.
  - Stimulus: ldsh at 0x012.
  - Check: 0xFFFFBEEF.
  - Stimulus: lduh at 0x010.
  - Check: 0x0000DEAD.
- **Partial stores:**
  - Stimulus: stb with `data_in`=0x12345699 to 0x011, then ld from 0x010.
  - Check: 0xDE99BEEF.
  - Stimulus: sth 0xAAAA5555 to 0x012.
  - Check: word reads 0xDE995555.
- **Handshake:**
  - Stimulus: hold `RAM_enable` high 5 cycles after `MFC`.
  - Check: `MFC` stays 1 throughout, then falls the edge after `RAM_enable`=0.
  - Stimulus: drop `RAM_enable` in WAIT.
  - Check: the access still completes, with a one-cycle `MFC`.
- **Misalignment:**
  - Stimulus: ld at 0x011 with `MEM_ALIGN_CHECK_EN` defined.
  - Check: `misaligned`=1, `data_out`=0, memory unchanged.
  - Stimulus: same request with the macro undefined.
  - Check: returns the word at 0x010.
- **Reset mid-operation:**
  - Stimulus: st 0x11111111 to 0x020, assert `rst_n`=0 during WAIT, then ld from 0x020.
  - Check: prior contents are returned and `MFC`=0 immediately on reset.
